ifu_fetch: RTL and testbench

//  Instruction fetch stage between the PC register and the decoder.
//  - Takes one PC at a time, issues a single-beat read on the instruction memory port and holds the result.
//  - Hands {inst, pc, fault} to decode via valid/ready.
//  - Discards in-flight fetches on a redirect (flush).

---
 rtl/npc_pkg.sv | 13 +
 rtl/ifu_fetch_if.sv | 21 ++
 rtl/ifu_fetch.sv | 119 +++++++++++
 tb/tb_ifu_fetch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Types and constants shared by the next-PC / fetch front end.
package npc_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } ifu_state_e;
endpackage

// File: rtl/ifu_fetch_if.sv
// Single-beat instruction memory read port: request channel plus response channel.
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one PC in flight, single-beat memory read, result held for decode.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int XLEN      = npc_pkg::XLEN,
    parameter bit ALIGN_CHK = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             pc_valid_i,
    output logic             pc_ready_o,
    input  logic             flush_i,
    ifu_fetch_if.master      mem,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [XLEN-1:0]  inst_o,
    output logic [XLEN-1:0]  inst_pc_o,
    output logic             inst_fault_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    ifu_state_e       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic             fault_q, fault_d;
    logic             kill_q, kill_d;
    logic             inst_valid_q, inst_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            inst_q       <= '0;
            fault_q      <= 1'b0;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            fault_q      <= fault_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        kill_d  = kill_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pc_valid_i && !flush_i) begin
                    pc_d = pc_i;
                    if (ALIGN_CHK && (pc_i[1:0] != 2'b00)) begin
                        fault_d = 1'b1;
                        inst_d  = '0;
                        state_d = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A flushed request cannot be withdrawn, so remember to drop its response.
                if (flush_i) kill_d = 1'b1;
                if (mem.req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem.rsp_valid) begin
                    if (flush_i || kill_q) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        inst_d  = mem.rsp_data;
                        fault_d = mem.rsp_err;
                        state_d = HOLD;
                    end
                end else if (flush_i) begin
                    kill_d  = 1'b0;
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (inst_ready_i) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DROP: begin
                if (mem.rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        inst_valid_d = (state_d == HOLD);
    end

    assign pc_ready_o    = (state_q == IDLE);
    assign mem.req_valid = (state_q == REQ);
    assign mem.req_addr  = pc_q;
    assign inst_valid_o  = inst_valid_q;
    assign inst_o        = inst_q;
    assign inst_pc_o     = pc_q;
    assign inst_fault_o  = fault_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run against a transaction-level model.
module tb_ifu_fetch;
    import npc_pkg::*;

    logic        clk, rst;
    logic [31:0] pc;
    logic        pc_valid, pc_ready, flush;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst, inst_pc;
    logic [31:0] cnt;
    logic        pc_ready2, inst_valid2, inst_fault2;
    logic [31:0] inst2, inst_pc2;
    logic [1:0]  cnt2;

    int errors = 0;
    int checks = 0;

    ifu_fetch_if #(.XLEN(32)) m ();
    ifu_fetch_if #(.XLEN(32)) m2 ();

    assign m2.req_ready = m.req_ready;
    assign m2.rsp_valid = m.rsp_valid;
    assign m2.rsp_data  = m.rsp_data;
    assign m2.rsp_err   = m.rsp_err;

    ifu_fetch #(.XLEN(32), .ALIGN_CHK(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready),
        .flush_i(flush), .mem(m.master), .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
        .inst_o(inst), .inst_pc_o(inst_pc), .inst_fault_o(inst_fault), .fetch_cnt_o(cnt)
    );

    // Narrow-counter copy, used only to observe wraparound.
    ifu_fetch #(.XLEN(32), .ALIGN_CHK(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready2),
        .flush_i(flush), .mem(m2.master), .inst_valid_o(inst_valid2), .inst_ready_i(inst_ready),
        .inst_o(inst2), .inst_pc_o(inst_pc2), .inst_fault_o(inst_fault2), .fetch_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[4:2] == 3'd7;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pc = '0; pc_valid = 0; flush = 0; inst_ready = 0;
        m.req_ready = 0; m.rsp_valid = 0; m.rsp_data = '0; m.rsp_err = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        pc = RESET_PC; pc_valid = 1; m.req_ready = 1;
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL reset_pc_ready: got %b want 1", pc_ready); end
        checks++; if ({m.req_valid, inst_valid, inst_fault} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {m.req_valid, inst_valid, inst_fault}); end
        checks++; if ({inst, inst_pc, cnt} !== 96'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", {inst, inst_pc, cnt}); end
        @(negedge clk);
        rst = 0;
        clear_inputs();
        tick();
        checks++; if (pc_ready !== 1'b1 || m.req_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b%b want 10", pc_ready, m.req_valid); end
    endtask

    task automatic test_aligned();
        do_reset();
        pc = RESET_PC; pc_valid = 1; m.req_ready = 1;
        tick();
        pc_valid = 0;
        checks++; if (m.req_valid !== 1'b1 || m.req_addr !== RESET_PC || pc_ready !== 1'b0) begin errors++; $display("FAIL aligned_req: got v=%b a=%h want v=1 a=%h", m.req_valid, m.req_addr, RESET_PC); end
        tick();
        m.rsp_valid = 1; m.rsp_data = 32'h0000_0413; m.rsp_err = 0;
        checks++; if (inst_valid !== 1'b0 || m.req_valid !== 1'b0) begin errors++; $display("FAIL aligned_wait: got iv=%b rv=%b want 0 0", inst_valid, m.req_valid); end
        tick();
        m.rsp_valid = 0;
        checks++; if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, 32'h0000_0413, RESET_PC, 1'b0}) begin errors++; $display("FAIL aligned_hold: got v=%b i=%h pc=%h f=%b want 1 00000413 %h 0", inst_valid, inst, inst_pc, inst_fault, RESET_PC); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL aligned_cnt0: got %0d want 0", cnt); end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        checks++; if (cnt !== 32'd1 || inst_valid !== 1'b0 || pc_ready !== 1'b1) begin errors++; $display("FAIL aligned_done: got cnt=%0d iv=%b pr=%b want 1 0 1", cnt, inst_valid, pc_ready); end
    endtask

    task automatic test_backpressure();
        do_reset();
        pc = 32'h8000_0040; pc_valid = 1; m.req_ready = 0;
        tick();
        pc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (m.req_valid !== 1'b1 || m.req_addr !== 32'h8000_0040) begin errors++; $display("FAIL bp_req_stable: cycle %0d got v=%b a=%h want 1 80000040", i, m.req_valid, m.req_addr); end
            tick();
        end
        m.req_ready = 1;
        checks++; if (m.req_valid !== 1'b1) begin errors++; $display("FAIL bp_req_final: got %b want 1", m.req_valid); end
        tick();
        checks++; if (m.req_valid !== 1'b0) begin errors++; $display("FAIL bp_single_req: got %b want 0", m.req_valid); end
        m.rsp_valid = 1; m.rsp_data = 32'h00A0_0093;
        tick();
        m.rsp_valid = 0; m.req_ready = 0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, 32'h00A0_0093, 32'h8000_0040, 1'b0}) begin errors++; $display("FAIL bp_hold_stable: cycle %0d got v=%b i=%h pc=%h f=%b", i, inst_valid, inst, inst_pc, inst_fault); end
            tick();
        end
        inst_ready = 1;
        checks++; if (inst_valid !== 1'b1 || cnt !== 32'd0) begin errors++; $display("FAIL bp_before_accept: got v=%b cnt=%0d want 1 0", inst_valid, cnt); end
        tick();
        checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL bp_cnt: got %0d want 1", cnt); end
        tick();
        inst_ready = 0;
        checks++; if (cnt !== 32'd1 || inst_valid !== 1'b0) begin errors++; $display("FAIL bp_cnt_once: got cnt=%0d v=%b want 1 0", cnt, inst_valid); end
    endtask

    task automatic test_misaligned();
        do_reset();
        pc = 32'h8000_0002; pc_valid = 1; m.req_ready = 1;
        tick();
        pc_valid = 0;
        checks++; if (m.req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b want 0", m.req_valid); end
        checks++; if ({inst_valid, inst_fault, inst, inst_pc} !== {1'b1, 1'b1, 32'h0, 32'h8000_0002}) begin errors++; $display("FAIL mis_hold: got v=%b f=%b i=%h pc=%h want 1 1 0 80000002", inst_valid, inst_fault, inst, inst_pc); end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        checks++; if (cnt !== 32'd1 || m.req_valid !== 1'b0) begin errors++; $display("FAIL mis_cnt: got cnt=%0d rv=%b want 1 0", cnt, m.req_valid); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        pc = 32'h8000_0080; pc_valid = 1; m.req_ready = 1;
        tick();
        pc_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0; m.rsp_valid = 1; m.rsp_data = 32'hDEAD_BEEF;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL fw_drop_busy: got pr=%b want 0", pc_ready); end
        tick();
        m.rsp_valid = 0;
        checks++; if (pc_ready !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL fw_discard: got pr=%b iv=%b want 1 0", pc_ready, inst_valid); end
        pc = 32'h8000_0100; pc_valid = 1;
        tick();
        pc_valid = 0;
        checks++; if (m.req_addr !== 32'h8000_0100 || m.req_valid !== 1'b1) begin errors++; $display("FAIL fw_next_req: got v=%b a=%h want 1 80000100", m.req_valid, m.req_addr); end
        tick();
        m.rsp_valid = 1; m.rsp_data = 32'h1234_5013;
        tick();
        m.rsp_valid = 0;
        checks++; if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, 32'h1234_5013, 32'h8000_0100, 1'b0}) begin errors++; $display("FAIL fw_next_inst: got v=%b i=%h pc=%h f=%b", inst_valid, inst, inst_pc, inst_fault); end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL fw_cnt: got %0d want 1", cnt); end
    endtask

    task automatic test_flush_req();
        do_reset();
        pc = 32'h8000_00C0; pc_valid = 1; m.req_ready = 0;
        tick();
        pc_valid = 0; flush = 1;
        checks++; if (m.req_valid !== 1'b1) begin errors++; $display("FAIL fr_req_on_flush: got %b want 1", m.req_valid); end
        tick();
        flush = 0;
        checks++; if (m.req_valid !== 1'b1 || m.req_addr !== 32'h8000_00C0) begin errors++; $display("FAIL fr_req_held: got v=%b a=%h want 1 800000c0", m.req_valid, m.req_addr); end
        tick();
        m.req_ready = 1;
        tick();
        m.req_ready = 0; m.rsp_valid = 1; m.rsp_data = 32'hCAFE_0013;
        checks++; if (m.req_valid !== 1'b0 || pc_ready !== 1'b0) begin errors++; $display("FAIL fr_wait: got rv=%b pr=%b want 0 0", m.req_valid, pc_ready); end
        tick();
        m.rsp_valid = 0;
        checks++; if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin errors++; $display("FAIL fr_dropped: got iv=%b pr=%b want 0 1", inst_valid, pc_ready); end
        tick();
        checks++; if (inst_valid !== 1'b0 || cnt !== 32'd0) begin errors++; $display("FAIL fr_no_inst: got iv=%b cnt=%0d want 0 0", inst_valid, cnt); end
    endtask

    task automatic test_err_reset();
        do_reset();
        pc = 32'h8000_0200; pc_valid = 1; m.req_ready = 1;
        tick();
        pc_valid = 0;
        tick();
        m.rsp_valid = 1; m.rsp_err = 1; m.rsp_data = 32'h0000_0000;
        tick();
        m.rsp_valid = 0; m.rsp_err = 0;
        checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0200) begin errors++; $display("FAIL err_fault: got v=%b f=%b pc=%h want 1 1 80000200", inst_valid, inst_fault, inst_pc); end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        pc = 32'h8000_0204; pc_valid = 1;
        tick();
        pc_valid = 0;
        tick();
        m.rsp_valid = 1; m.rsp_data = 32'h0010_0073;
        tick();
        m.rsp_valid = 0;
        checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b0 || cnt !== 32'd1) begin errors++; $display("FAIL err_second: got v=%b f=%b cnt=%0d want 1 0 1", inst_valid, inst_fault, cnt); end
        #2 rst = 1;
        #1;
        checks++; if (inst_valid !== 1'b0 || cnt !== 32'd0 || pc_ready !== 1'b1) begin errors++; $display("FAIL err_async_rst: got v=%b cnt=%0d pr=%b want 0 0 1", inst_valid, cnt, pc_ready); end
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        inst_ready = 1;
        for (int k = 1; k <= 5; k++) begin
            pc = 32'h8000_0001 + 32'(k) * 8; pc_valid = 1;
            tick();
            pc_valid = 0;
            tick();
            checks++; if (cnt !== 32'(k) || cnt2 !== 2'(k % 4) || m2.req_valid !== 1'b0) begin errors++; $display("FAIL wrap_cnt: k=%0d got cnt=%0d cnt2=%0d want %0d %0d", k, cnt, cnt2, k, k % 4); end
        end
        inst_ready = 0;
    endtask

    // Model tracks one fetch as a transaction: accepted pc, whether a flush killed it, requests seen.
    task automatic test_random();
        int          cnt_m = 0;
        int          rsp_cd = 0;
        int          nreq = 0;
        logic        pend = 0, killed = 0, mis = 0;
        logic [31:0] epc = '0, rsp_addr = '0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            m.rsp_valid = 0; m.rsp_err = 0; m.rsp_data = '0;
            if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    m.rsp_valid = 1; m.rsp_data = mem_word(rsp_addr); m.rsp_err = mem_err(rsp_addr);
                end
            end
            m.req_ready = ($urandom % 3) != 0;
            inst_ready  = ($urandom % 2) != 0;
            flush       = ($urandom % 14) == 0;
            pc_valid    = ($urandom % 4) != 0;
            pc          = RESET_PC + ($urandom % 256) * 4 + ((($urandom % 6) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);

            if (pc_ready) begin
                checks++; if (pend && !killed) begin errors++; $display("FAIL rnd_lost_fetch: cycle %0d pc %h never delivered", c, epc); end
                pend = 0;
            end
            checks++; if (cnt !== 32'(cnt_m)) begin errors++; $display("FAIL rnd_cnt: cycle %0d got %0d want %0d", c, cnt, cnt_m); end
            if (inst_valid) begin
                checks++;
                if (!pend || killed) begin
                    errors++; $display("FAIL rnd_spurious_inst: cycle %0d got valid pend=%b killed=%b", c, pend, killed);
                end else if ({inst, inst_pc, inst_fault} !== {(mis ? 32'h0 : mem_word(epc)), epc, (mis | mem_err(epc))}) begin
                    errors++; $display("FAIL rnd_inst: cycle %0d got i=%h pc=%h f=%b want i=%h pc=%h f=%b", c, inst, inst_pc, inst_fault, mis ? 32'h0 : mem_word(epc), epc, mis | mem_err(epc));
                end
            end
            if (m.req_valid) begin
                checks++; if (!pend || mis || nreq != 0 || m.req_addr !== epc) begin errors++; $display("FAIL rnd_req: cycle %0d got a=%h want %h (pend=%b mis=%b nreq=%0d)", c, m.req_addr, epc, pend, mis, nreq); end
            end

            if (pc_ready && pc_valid && !flush) begin
                pend = 1; killed = 0; nreq = 0; epc = pc; mis = (pc[1:0] != 2'b00);
            end else if (pend && flush) begin
                killed = 1;
            end
            if (inst_valid && inst_ready && !flush && pend && !killed) begin
                cnt_m++; pend = 0;
            end
            if (m.req_valid && m.req_ready) begin
                nreq++; rsp_cd = 1 + ($urandom % 3); rsp_addr = m.req_addr;
            end
            tick();
        end
        // Let the last response land before leaving the random run.
        while (rsp_cd > 0) begin
            rsp_cd--;
            m.rsp_valid = (rsp_cd == 0); m.rsp_data = mem_word(rsp_addr); m.rsp_err = 0;
            m.req_ready = 0; pc_valid = 0; flush = 0; inst_ready = 1;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_aligned();
        test_backpressure();
        test_misaligned();
        test_flush_wait();
        test_flush_req();
        test_err_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
